controle_multiciclo: RTL and testbench

Multicycle control unit for the single-issue datapath. It sequences every instruction through the four-phase one-hot `estado` bus consumed by the PC adder, register file and memory port. It latches and decodes the fetched 32-bit RV32 instruction and drives the datapath strobes. In the PC-update phase it drives `pcsrc`, `imediato` and `negativo` (branch decision, offset magnitude and sign) to the PC adder.

---
 rtl/controle_multiciclo.sv | 207 ++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : controle_multiciclo                                          |
// | Description : Multicycle control unit for the RV32 single-issue datapath.  |
// |               Sequences BUSCA/DECOD/EXEC/ESCRITA on a one-hot bus, latches |
// |               and decodes the instruction, drives datapath strobes and the |
// |               PC-adder branch controls (pcsrc, imediato, negativo).        |
// |               Optional feature macro: CTRL_TIMEOUT_EN (memory watchdog).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module controle_multiciclo #(
  parameter int MAX_ESPERA = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrucao,
  input  logic        zero,
  input  logic        mem_pronto,
  output logic [3:0]  estado,
  output logic        pcsrc,
  output logic [11:0] imediato,
  output logic        negativo,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        erro
);

  typedef enum logic [3:0] {
    BUSCA   = 4'b0001,
    DECOD   = 4'b0010,
    EXEC    = 4'b0100,
    ESCRITA = 4'b1000
  } estado_t;

  estado_t     estado_q;
  logic [31:0] ir_q;
  logic        pcsrc_q;
  logic [11:0] imediato_q;
  logic        negativo_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        alu_src_q;
  logic        mem_to_reg_q;
  logic [1:0]  alu_op_q;
  logic        erro_q;

`ifdef CTRL_TIMEOUT_EN
  localparam int c_espera_w = (MAX_ESPERA > 1) ? $clog2(MAX_ESPERA) : 1;
  logic [c_espera_w-1:0] espera_q;
`else
  localparam int c_unused_espera = MAX_ESPERA;
`endif

  // Decode source: the live fetch bus in BUSCA (so DECOD sees registered
  // outputs already), the latched IR in every later phase.
  logic [31:0] w_ir;
  logic [12:0] w_off;
  logic [11:0] w_mag;
  logic [2:0]  w_f3;
  logic        w_r, w_addi, w_lw, w_sw, w_beq, w_bne, w_br, w_legal, w_mem;
  logic [1:0]  w_alu_op;
  logic        w_alu_src, w_m2r, w_neg;
  logic [11:0] w_imm;
  logic        w_unused_bits;

  // Combinational instruction decode and branch-offset magnitude
  always_comb begin
    w_ir   = (estado_q == BUSCA) ? instrucao : ir_q;
    w_f3   = w_ir[14:12];
    w_off  = {w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0};
    // Low 12 bits of the 13-bit negation are the magnitude for every
    // representable offset except -4096, which is rejected below.
    w_mag  = w_ir[31] ? (~w_off[11:0] + 12'd1) : w_off[11:0];
    w_r    = 1'b0;
    w_addi = 1'b0;
    w_lw   = 1'b0;
    w_sw   = 1'b0;
    w_beq  = 1'b0;
    w_bne  = 1'b0;
    case (w_ir[6:0])
      7'b0110011: begin
        if ((w_ir[31:25] == 7'b0000000 &&
             (w_f3 == 3'b000 || w_f3 == 3'b110 || w_f3 == 3'b111)) ||
            (w_ir[31:25] == 7'b0100000 && w_f3 == 3'b000))
          w_r = 1'b1;
      end
      7'b0010011: w_addi = (w_f3 == 3'b000);
      7'b0000011: w_lw   = (w_f3 == 3'b010);
      7'b0100011: w_sw   = (w_f3 == 3'b010);
      7'b1100011: begin
        if (w_off != 13'h1000) begin
          w_beq = (w_f3 == 3'b000);
          w_bne = (w_f3 == 3'b001);
        end
      end
      default: ;
    endcase
    w_br      = w_beq | w_bne;
    w_mem     = w_lw | w_sw;
    w_legal   = w_r | w_addi | w_mem | w_br;
    w_alu_op  = w_r ? 2'b10 : (w_br ? 2'b01 : 2'b00);
    w_alu_src = w_addi | w_mem;
    w_m2r     = w_lw;
    w_imm     = w_br ? w_mag : 12'd0;
    w_neg     = w_br & w_ir[31];
  end

  // Register-select fields are consumed by the register file, not here
  assign w_unused_bits = ^w_ir[24:15];

  // Phase sequencer with registered datapath controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= BUSCA;
      ir_q         <= 32'd0;
      pcsrc_q      <= 1'b0;
      imediato_q   <= 12'd0;
      negativo_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= 2'b00;
      erro_q       <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
      espera_q     <= '0;
`endif
    end else begin
      case (estado_q)
        BUSCA: begin
          estado_q     <= DECOD;
          ir_q         <= instrucao;
          alu_op_q     <= w_alu_op;
          alu_src_q    <= w_alu_src;
          mem_to_reg_q <= w_m2r;
          imediato_q   <= w_imm;
          negativo_q   <= w_neg;
`ifdef CTRL_TIMEOUT_EN
          espera_q     <= '0;
`endif
        end
        DECOD: begin
          estado_q    <= EXEC;
          mem_read_q  <= w_lw;
          mem_write_q <= w_sw;
        end
        EXEC: begin
          if (!w_mem || mem_pronto) begin
            estado_q    <= ESCRITA;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            // zero is captured here directly as the branch decision
            pcsrc_q     <= (w_beq & zero) | (w_bne & ~zero);
            reg_write_q <= w_r | w_addi | w_lw;
            erro_q      <= ~w_legal;
          end
`ifdef CTRL_TIMEOUT_EN
          else if (espera_q == c_espera_w'(MAX_ESPERA - 1)) begin
            // Memory never answered: abandon the access
            estado_q    <= ESCRITA;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pcsrc_q     <= 1'b0;
            reg_write_q <= 1'b0;
            erro_q      <= 1'b1;
          end else begin
            espera_q <= espera_q + 1'b1;
          end
`endif
        end
        default: begin
          estado_q     <= BUSCA;
          pcsrc_q      <= 1'b0;
          imediato_q   <= 12'd0;
          negativo_q   <= 1'b0;
          reg_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          alu_src_q    <= 1'b0;
          mem_to_reg_q <= 1'b0;
          alu_op_q     <= 2'b00;
          erro_q       <= 1'b0;
        end
      endcase
    end
  end

  assign estado     = estado_q;
  assign pcsrc      = pcsrc_q;
  assign imediato   = imediato_q;
  assign negativo   = negativo_q;
  assign reg_write  = reg_write_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign alu_src    = alu_src_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_op     = alu_op_q;
  assign erro       = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_controle_multiciclo                                       |
// | Description : Scoreboard bench for controle_multiciclo. Stimulus pushes    |
// |               one expected output vector per cycle; a negedge monitor pops |
// |               and compares. Timeout cases need CTRL_TIMEOUT_EN.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_controle_multiciclo;
`ifdef CTRL_TIMEOUT_EN
  localparam int C_MAX = 2;
`else
  localparam int C_MAX = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instrucao = 32'd0;
  logic        zero = 1'b0;
  logic        mem_pronto = 1'b0;
  logic [3:0]  estado;
  logic        pcsrc, negativo, reg_write, mem_read, mem_write, alu_src, mem_to_reg, erro;
  logic [11:0] imediato;
  logic [1:0]  alu_op;

  controle_multiciclo #(.MAX_ESPERA(C_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .zero(zero),
    .mem_pronto(mem_pronto), .estado(estado), .pcsrc(pcsrc),
    .imediato(imediato), .negativo(negativo), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [25:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   tests = 0;
  int   fails = 0;

  // Field order: estado, pcsrc, imediato, negativo, reg_write, mem_read,
  // mem_write, alu_src, mem_to_reg, alu_op, erro
  function automatic logic [25:0] mk(input logic [3:0] st, input logic pc,
      input logic [11:0] imm, input logic neg, input logic rw, input logic mr,
      input logic mw, input logic src, input logic m2r, input logic [1:0] op,
      input logic er);
    return {st, pc, imm, neg, rw, mr, mw, src, m2r, op, er};
  endfunction

  wire [25:0] w_act = {estado, pcsrc, imediato, negativo, reg_write, mem_read,
                       mem_write, alu_src, mem_to_reg, alu_op, erro};

  // Monitor: compare once per cycle, away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      tests++;
      if (w_act !== e_mon.v) begin
        fails++;
        $display("FAIL %s: got %07h (st=%b pc=%b imm=%0d neg=%b rw=%b mr=%b mw=%b src=%b m2r=%b op=%b er=%b) expected %07h",
                 e_mon.nm, w_act, estado, pcsrc, imediato, negativo, reg_write,
                 mem_read, mem_write, alu_src, mem_to_reg, alu_op, erro, e_mon.v);
      end
    end
  end

  task automatic push(input string nm, input logic [25:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    push({nm, "/rst0"}, mk(4'b0001, 0, 12'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    tick();
    push({nm, "/rst1"}, mk(4'b0001, 0, 12'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    tick();
    rst_n = 1'b1;
  endtask

  // One instruction: hand-computed decode values in, per-cycle vectors pushed
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic z,
      input int n_exec, input logic mp_last, input logic [1:0] op, input logic src,
      input logic m2r, input logic [11:0] imm, input logic neg, input logic mr,
      input logic mw, input logic rw, input logic pc, input logic er, input bit abort);
    push({nm, "/busca"}, mk(4'b0001, 0, 12'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    instrucao = ins; zero = ~z; mem_pronto = 1'b1;
    tick();
    push({nm, "/decod"}, mk(4'b0010, 0, imm, neg, 0, 0, 0, src, m2r, op, 0));
    instrucao = 32'hFFFF_FFFF; mem_pronto = 1'b1;
    tick();
    for (int k = 0; k < n_exec; k++) begin
      if (abort && k == 1) begin
        do_reset({nm, "/abort"});
        return;
      end
      push({nm, "/exec"}, mk(4'b0100, 0, imm, neg, 0, mr, mw, src, m2r, op, 0));
      zero = z;
      mem_pronto = (k == n_exec - 1) ? mp_last : 1'b0;
      tick();
    end
    push({nm, "/escrita"}, mk(4'b1000, pc, imm, neg, rw, 0, 0, src, m2r, op, er));
    zero = ~z; mem_pronto = 1'b1;
    tick();
  endtask

  initial begin
    tick();
    do_reset("reset");
    //        name          instr         z  nEx mpL op    src m2r imm      neg mr mw rw pc er abort
    run_instr("add",       32'h002081B3, 1, 1, 0, 2'b10, 0, 0, 12'd0,    0, 0, 0, 1, 0, 0, 0);
    run_instr("addi",      32'h00500093, 0, 1, 0, 2'b00, 1, 0, 12'd0,    0, 0, 0, 1, 0, 0, 0);
    run_instr("beq_z1",    32'hFE000CE3, 1, 1, 0, 2'b01, 0, 0, 12'd8,    1, 0, 0, 0, 1, 0, 0);
    run_instr("beq_z0",    32'hFE000CE3, 0, 1, 0, 2'b01, 0, 0, 12'd8,    1, 0, 0, 0, 0, 0, 0);
    run_instr("bne_z1",    32'hFE001CE3, 1, 1, 0, 2'b01, 0, 0, 12'd8,    1, 0, 0, 0, 0, 0, 0);
    run_instr("bne_z0",    32'hFE001CE3, 0, 1, 0, 2'b01, 0, 0, 12'd8,    1, 0, 0, 0, 1, 0, 0);
    run_instr("beq_fwd16", 32'h00000863, 1, 1, 0, 2'b01, 0, 0, 12'd16,   0, 0, 0, 0, 1, 0, 0);
    run_instr("beq_p4094", 32'h7E000FE3, 1, 1, 0, 2'b01, 0, 0, 12'd4094, 0, 0, 0, 0, 1, 0, 0);
    run_instr("bne_m4094", 32'h80001163, 0, 1, 0, 2'b01, 0, 0, 12'd4094, 1, 0, 0, 0, 1, 0, 0);
    run_instr("lw_wait3",  32'h00012083, 0, 4, 1, 2'b00, 1, 1, 12'd0,    0, 1, 0, 1, 0, 0, 0);
    run_instr("sw_nowait", 32'h00112023, 0, 1, 1, 2'b00, 1, 0, 12'd0,    0, 0, 1, 0, 0, 0, 0);
    run_instr("lw_abort",  32'h00012083, 0, 4, 1, 2'b00, 1, 1, 12'd0,    0, 1, 0, 1, 0, 0, 1);
    run_instr("add_after", 32'h002081B3, 0, 1, 0, 2'b10, 0, 0, 12'd0,    0, 0, 0, 1, 0, 0, 0);
    run_instr("illegal",   32'hFFFFFFFF, 1, 1, 0, 2'b00, 0, 0, 12'd0,    0, 0, 0, 0, 0, 1, 0);
    run_instr("beq_m4096", 32'h80000063, 1, 1, 0, 2'b00, 0, 0, 12'd0,    0, 0, 0, 0, 0, 1, 0);
    run_instr("xor_illeg", 32'h0020C1B3, 1, 1, 0, 2'b00, 0, 0, 12'd0,    0, 0, 0, 0, 0, 1, 0);
`ifdef CTRL_TIMEOUT_EN
    run_instr("sw_tmo",    32'h00112023, 0, 2, 0, 2'b00, 1, 0, 12'd0,    0, 0, 1, 0, 0, 1, 0);
    run_instr("lw_wait1",  32'h00012083, 0, 2, 1, 2'b00, 1, 1, 12'd0,    0, 1, 0, 1, 0, 0, 0);
`else
    run_instr("lw_wait8",  32'h00012083, 1, 9, 1, 2'b00, 1, 1, 12'd0,    0, 1, 0, 1, 0, 0, 0);
`endif
    run_instr("add_last",  32'h002081B3, 1, 1, 0, 2'b10, 0, 0, 12'd0,    0, 0, 0, 1, 0, 0, 0);
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
